// File: rtl/bus_copy_master.sv
// Word-copy DMA initiator: reads LEN words from SRC, writes each to DST over a
// req/ack/resp bus, aborting on read timeout or responder parity error.
module bus_copy_master #(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [31:0]      src_addr_bi,
  input  logic [31:0]      dst_addr_bi,
  input  logic [LEN_W-1:0] len_bi,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             bus_req_o,
  output logic             bus_we_o,
  output logic [31:0]      bus_addr_bo,
  output logic [3:0]       bus_be_bo,
  output logic [31:0]      bus_wdata_bo,
  input  logic             bus_ack_i,
  input  logic             bus_resp_i,
  input  logic [31:0]      bus_rdata_bi,
  input  logic             parity_err_i
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_t;

  state_t           state_q;
  logic [31:0]      src_q, dst_q, src_d, dst_d;
  logic [LEN_W-1:0] rem_q;
  logic [TW-1:0]    tmo_q;
  logic             busy_q, done_q, err_q, req_q, we_q;
  logic [31:0]      addr_q, wdata_q;

  // Post-increment addresses; wrap modulo 2^32 is intentional
  always_comb begin
    src_d = src_q + 32'd4;
    dst_d = dst_q + 32'd4;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      tmo_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            src_q <= src_addr_bi & ~32'h3;
            dst_q <= dst_addr_bi & ~32'h3;
            rem_q <= len_bi;
            if (len_bi == '0) begin
              done_q <= 1'b1;
            end else begin
              busy_q  <= 1'b1;
              req_q   <= 1'b1;
              we_q    <= 1'b0;
              addr_q  <= src_addr_bi & ~32'h3;
              state_q <= RD_REQ;
            end
          end
        end
        RD_REQ: begin
          if (bus_ack_i) begin
            req_q   <= 1'b0;
            tmo_q   <= '0;
            state_q <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (bus_resp_i) begin
            if (parity_err_i) begin
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              wdata_q <= bus_rdata_bi;
              req_q   <= 1'b1;
              we_q    <= 1'b1;
              addr_q  <= dst_q;
              state_q <= WR_REQ;
            end
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        WR_REQ: begin
          if (bus_ack_i) begin
            src_q <= src_d;
            dst_q <= dst_d;
            rem_q <= rem_q - 1'b1;
            we_q  <= 1'b0;
            if (rem_q == LEN_W'(1)) begin
              req_q   <= 1'b0;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              req_q   <= 1'b1;
              addr_q  <= src_d;
              state_q <= RD_REQ;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign bus_req_o    = req_q;
  assign bus_we_o     = we_q;
  assign bus_addr_bo  = addr_q;
  assign bus_be_bo    = 4'hf;
  assign bus_wdata_bo = wdata_q;

endmodule

// File: tb/tb_bus_copy_master.sv
// Bench for bus_copy_master: RAM responder model, table of copy vectors and
// hand-written sequences for timeout, parity abort, address wrap and reset.
module tb_bus_copy_master;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] src, dst;
  logic [15:0] len;
  logic        busy, done, err, req, we;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;
  logic        ack, resp, parity;

  always #5 clk = ~clk;

  bus_copy_master #(.LEN_W(16), .TIMEOUT(64)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .src_addr_bi(src), .dst_addr_bi(dst), .len_bi(len),
    .busy_o(busy), .done_o(done), .err_o(err),
    .bus_req_o(req), .bus_we_o(we), .bus_addr_bo(addr), .bus_be_bo(be),
    .bus_wdata_bo(wdata), .bus_ack_i(ack), .bus_resp_i(resp),
    .bus_rdata_bi(rdata), .parity_err_i(parity)
  );

  // Responder model: 1024-word RAM, ack after ack_delay stall cycles, resp next cycle
  logic [31:0] mem [0:1023];
  int          ack_delay = 0;
  bit          no_resp = 1'b0;
  int          par_on_read = 0;
  bit          clr = 1'b0;
  int          stall_q, rd_cnt;
  logic [31:0] rd_addr0, rd_addr1;
  bit          hold_q, unstable, req_seen, both_seen, be_bad;
  logic [31:0] h_addr, h_wdata;
  logic        h_we;

  function automatic logic [31:0] pat(input logic [9:0] i);
    return {16'hC0DE, 6'b0, i};
  endfunction

  assign ack = req && (stall_q >= ack_delay);

  always @(posedge clk) begin
    resp   <= 1'b0;
    parity <= 1'b0;
    if (clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= pat(10'(i));
      rd_cnt <= 0; stall_q <= 0; hold_q <= 1'b0;
      unstable <= 1'b0; req_seen <= 1'b0; both_seen <= 1'b0; be_bad <= 1'b0;
      rd_addr0 <= '1; rd_addr1 <= '1;
    end else begin
      stall_q <= (req && !ack) ? stall_q + 1 : 0;
      if (req && ack) begin
        if (we) mem[addr[11:2]] <= wdata;
        else begin
          rd_cnt <= rd_cnt + 1;
          if (rd_cnt == 0) rd_addr0 <= addr;
          if (rd_cnt == 1) rd_addr1 <= addr;
          if (!no_resp) begin
            resp   <= 1'b1;
            rdata  <= mem[addr[11:2]];
            parity <= (rd_cnt + 1 == par_on_read);
          end
        end
      end
      if (hold_q && (!req || addr != h_addr || we != h_we || wdata != h_wdata)) unstable <= 1'b1;
      hold_q  <= req && !ack;
      h_addr  <= addr; h_we <= we; h_wdata <= wdata;
      if (req) req_seen <= 1'b1;
      if (done && err) both_seen <= 1'b1;
      if (req && be != 4'hf) be_bad <= 1'b1;
    end
  end

  int n_pass = 0, n_tot = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic clear_model();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  // Start a transfer; cycle numbers count the start cycle as 0
  task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                          input bit restart, output int done_cyc, output int err_cyc,
                          output int busy_cyc);
    done_cyc = -1; err_cyc = -1; busy_cyc = 0;
    @(negedge clk); src = s; dst = d; len = n; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (restart && k == 1) begin start = 1'b1; len = 16'd7; end
      if (restart && k == 2) start = 1'b0;
      if (busy) busy_cyc++;
      if (done) begin done_cyc = k + 1; break; end
      if (err) begin err_cyc = k + 1; break; end
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    int          dly;
    int          exp_done;
    int          exp_busy;
  } vec_t;

  vec_t vecs [5];
  int   dc, ec, bc;

  initial begin
    vecs[0] = '{32'h100, 32'h200, 16'd4, 0, 13, 12};
    vecs[1] = '{32'h040, 32'h400, 16'd2, 0,  7,  6};
    vecs[2] = '{32'h803, 32'hA01, 16'd1, 0,  4,  3};
    vecs[3] = '{32'h100, 32'h600, 16'd3, 5, 40, 39};
    vecs[4] = '{32'h010, 32'h020, 16'd0, 0,  1,  0};

    rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_err", {31'b0, err}, 0);
    chk("rst_req", {31'b0, req}, 0);
    chk("rst_we", {31'b0, we}, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_be", {28'b0, be}, 32'hf);
    @(negedge clk); rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      ack_delay = vecs[v].dly;
      clear_model();
      run_xfer(vecs[v].src, vecs[v].dst, vecs[v].len, 1'b0, dc, ec, bc);
      chk($sformatf("v%0d_done_cycle", v), dc, vecs[v].exp_done);
      chk($sformatf("v%0d_busy_cycles", v), bc, vecs[v].exp_busy);
      chk($sformatf("v%0d_no_err", v), ec, -1);
      for (int w = 0; w < int'(vecs[v].len); w++) begin
        logic [9:0] si, di;
        si = vecs[v].src[11:2] + 10'(w);
        di = vecs[v].dst[11:2] + 10'(w);
        chk($sformatf("v%0d_word%0d", v, w), mem[di], pat(si));
      end
      chk($sformatf("v%0d_req_seen", v), {31'b0, req_seen}, (vecs[v].len != 0) ? 1 : 0);
      chk($sformatf("v%0d_stable", v), {31'b0, unstable}, 0);
      chk($sformatf("v%0d_be", v), {31'b0, be_bad}, 0);
    end

    // Start while busy is ignored
    ack_delay = 0;
    clear_model();
    run_xfer(32'h100, 32'h200, 16'd1, 1'b1, dc, ec, bc);
    chk("restart_done_cycle", dc, 4);
    @(posedge clk); #1;
    chk("restart_idle_after", {31'b0, busy}, 0);

    // Read response never arrives
    clear_model();
    no_resp = 1'b1;
    run_xfer(32'h100, 32'h200, 16'd1, 1'b0, dc, ec, bc);
    no_resp = 1'b0;
    chk("timeout_err_cycle", ec, 66);
    chk("timeout_no_done", dc, -1);
    chk("timeout_busy_low", {31'b0, busy}, 0);
    chk("timeout_req_low", {31'b0, req}, 0);

    // Parity error on second read of three
    clear_model();
    par_on_read = 2;
    run_xfer(32'h100, 32'h200, 16'd3, 1'b0, dc, ec, bc);
    par_on_read = 0;
    chk("parity_err_cycle", ec, 6);
    chk("parity_word0", mem[10'h80], pat(10'h40));
    chk("parity_word1_untouched", mem[10'h81], pat(10'h81));

    // Source address wraps past 2^32
    clear_model();
    run_xfer(32'hFFFF_FFFC, 32'h300, 16'd2, 1'b0, dc, ec, bc);
    chk("wrap_done_cycle", dc, 7);
    chk("wrap_rd0", rd_addr0, 32'hFFFF_FFFC);
    chk("wrap_rd1", rd_addr1, 32'h0);
    chk("wrap_word0", mem[10'hC0], pat(10'h3FF));
    chk("wrap_word1", mem[10'hC1], pat(10'h000));
    chk("both_pulses", {31'b0, both_seen}, 0);

    // Reset during WR_REQ drops the request on the next edge
    clear_model();
    ack_delay = 3;
    @(negedge clk); src = 32'h100; dst = 32'h200; len = 16'd2; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    begin
      int k;
      for (k = 0; k < 100; k++) begin
        if (req && we) break;
        @(posedge clk); #1;
      end
      chk("rst_reach_wr", k < 100 ? 1 : 0, 1);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_req", {31'b0, req}, 0);
    chk("midrst_busy", {31'b0, busy}, 0);
    chk("midrst_done", {31'b0, done}, 0);
    chk("midrst_err", {31'b0, err}, 0);
    @(posedge clk); #1;
    chk("midrst_quiet", {30'b0, done, err}, 0);
    @(negedge clk); rst = 1'b0;
    ack_delay = 0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
